// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 1-entry skid buffer and synchronous flush.
// Optional stall/bubble statistics counters are built when PIPE_STAGE_STAT_EN is defined.
module pipe_stage_skid #(
  parameter int          AUX_W     = 8,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ins,
  input  logic [31:0]      in_pc,
  input  logic [AUX_W-1:0] in_aux,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_ins,
  output logic [31:0]      out_pc,
  output logic [AUX_W-1:0] out_aux
`ifdef PIPE_STAGE_STAT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      bubble_cnt
`endif
);

  // Handshake: a word moves upstream->stage when in_valid && in_ready, and
  // stage->downstream when out_valid && out_ready, both sampled on posedge clk.
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_ins_q, out_ins_d;
  logic [31:0]        out_pc_q, out_pc_d;
  logic [AUX_W-1:0]   out_aux_q, out_aux_d;
  logic [31:0]        skid_ins_q, skid_ins_d;
  logic [31:0]        skid_pc_q, skid_pc_d;
  logic [AUX_W-1:0]   skid_aux_q, skid_aux_d;

  logic acc, pop;
  assign acc = in_valid && in_ready_q;
  assign pop = out_valid_q && out_ready;

  always_comb begin
    state_d    = state_q;
    out_ins_d  = out_ins_q;
    out_pc_d   = out_pc_q;
    out_aux_d  = out_aux_q;
    skid_ins_d = skid_ins_q;
    skid_pc_d  = skid_pc_q;
    skid_aux_d = skid_aux_q;
    if (flush) begin
      state_d    = S_EMPTY;
      skid_ins_d = '0;
      skid_pc_d  = '0;
      skid_aux_d = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (acc) begin
            state_d   = S_ONE;
            out_ins_d = in_ins;
            out_pc_d  = in_pc;
            out_aux_d = in_aux;
          end
        end
        S_ONE: begin
          if (acc && pop) begin
            out_ins_d = in_ins;
            out_pc_d  = in_pc;
            out_aux_d = in_aux;
          end else if (acc) begin
            state_d    = S_TWO;
            skid_ins_d = in_ins;
            skid_pc_d  = in_pc;
            skid_aux_d = in_aux;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (pop) begin
            state_d   = S_ONE;
            out_ins_d = skid_ins_q;
            out_pc_d  = skid_pc_q;
            out_aux_d = skid_aux_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    // A bubble shows NOP and zero side-band; the PC of the last word lingers.
    if (state_d == S_EMPTY) begin
      out_ins_d = NOP_INSTR;
      out_aux_d = '0;
    end
    out_valid_d = (state_d != S_EMPTY);
    in_ready_d  = (state_d != S_TWO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_ins_q   <= NOP_INSTR;
      out_pc_q    <= RESET_PC;
      out_aux_q   <= '0;
      skid_ins_q  <= '0;
      skid_pc_q   <= '0;
      skid_aux_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_ins_q   <= out_ins_d;
      out_pc_q    <= out_pc_d;
      out_aux_q   <= out_aux_d;
      skid_ins_q  <= skid_ins_d;
      skid_pc_q   <= skid_pc_d;
      skid_aux_q  <= skid_aux_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ins   = out_ins_q;
  assign out_pc    = out_pc_q;
  assign out_aux   = out_aux_q;

`ifdef PIPE_STAGE_STAT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; flush does not clear them.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (!out_valid_q && (bubble_cnt_q != 32'hFFFF_FFFF))
      bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

`ifndef SYNTHESIS
  a_out_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid_q && !out_ready && !flush) |=>
      (out_valid_q && $stable(out_ins_q) && $stable(out_pc_q) && $stable(out_aux_q)));
  a_no_acc_in_two: assert property (@(posedge clk) disable iff (reset)
    (state_q == S_TWO) |-> !acc);
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios followed by random traffic, scored
// against a queue model of the words the stage should be holding.
module tb_pipe_stage_skid;
  localparam int          AUX_W = 8;
  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] RPC   = 32'h0000_3000;
  localparam int          W     = 64 + AUX_W;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      in_ins, in_pc, out_ins, out_pc;
  logic [AUX_W-1:0] in_aux, out_aux;
`ifdef PIPE_STAGE_STAT_EN
  logic [31:0]      stall_cnt, bubble_cnt;
`endif

  pipe_stage_skid #(.AUX_W(AUX_W), .NOP_INSTR(NOP), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ins(in_ins), .in_pc(in_pc), .in_aux(in_aux),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ins(out_ins), .out_pc(out_pc), .out_aux(out_aux)
`ifdef PIPE_STAGE_STAT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard: words the stage holds, oldest first, packed {ins, pc, aux}.
  logic [W-1:0] exp_q[$];
  logic [31:0]  last_pc;
  logic [31:0]  m_stall, m_bubble;
  bit           started = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Reference model: advances on each rising edge from the bench's own inputs.
  always @(posedge clk) begin
    bit acc, pop;
    started = 1;
    if (reset) begin
      exp_q.delete();
      last_pc  = RPC;
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (exp_q.size() > 0) last_pc = exp_q[0][AUX_W +: 32];
      if (exp_q.size() > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (exp_q.size() == 0 && m_bubble != 32'hFFFF_FFFF) m_bubble++;
      acc = in_valid && (exp_q.size() < 2) && !flush;
      pop = (exp_q.size() > 0) && out_ready;
      if (pop) void'(exp_q.pop_front());
      if (flush) exp_q.delete();
      if (acc) exp_q.push_back({in_ins, in_pc, in_aux});
    end
  end

  // Monitor: compares the presented outputs against the model away from the edge.
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", W'(out_valid), W'(exp_q.size() > 0));
      chk("in_ready", W'(in_ready), W'(exp_q.size() < 2));
      if (exp_q.size() > 0) begin
        chk("out_word", {out_ins, out_pc, out_aux}, exp_q[0]);
      end else begin
        chk("bubble_word", {out_ins, out_pc, out_aux}, {NOP, last_pc, {AUX_W{1'b0}}});
      end
`ifdef PIPE_STAGE_STAT_EN
      chk("stall_cnt", W'(stall_cnt), W'(m_stall));
      chk("bubble_cnt", W'(bubble_cnt), W'(m_bubble));
`endif
    end
  end

  task automatic step(input logic v, input logic ordy, input logic fl, input logic rst,
                      input logic [31:0] pc);
    in_valid  = v;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    in_pc     = pc;
    in_ins    = $urandom;
    in_aux    = AUX_W'($urandom);
    @(negedge clk);
  endtask

  initial begin
    reset = 1; flush = 0; in_valid = 1; out_ready = 1;
    in_ins = 0; in_pc = 0; in_aux = 0;
    // Reset held two cycles with a word offered.
    step(1, 1, 0, 1, 32'h5000);
    step(1, 1, 0, 1, 32'h5004);
    chk("rst_out_valid", W'(out_valid), W'(1'b0));
    chk("rst_in_ready", W'(in_ready), W'(1'b1));
    chk("rst_word", {out_ins, out_pc, out_aux}, {NOP, RPC, {AUX_W{1'b0}}});
    // Streaming at full rate.
    step(1, 1, 0, 0, 32'h3000);
    step(1, 1, 0, 0, 32'h3004);
    step(1, 1, 0, 0, 32'h3008);
    repeat (3) step(0, 1, 0, 0, 32'h0);
    // Skid fill, hold, then drain.
    step(1, 0, 0, 0, 32'h3000);
    step(1, 0, 0, 0, 32'h3004);
    repeat (2) step(0, 0, 0, 0, 32'h0);
    repeat (3) step(0, 1, 0, 0, 32'h0);
    // Flush while full with a word offered.
    step(1, 0, 0, 0, 32'h3000);
    step(1, 0, 0, 0, 32'h3004);
    step(1, 0, 1, 0, 32'h3010);
    chk("flush_out_valid", W'(out_valid), W'(1'b0));
    chk("flush_in_ready", W'(in_ready), W'(1'b1));
    chk("flush_out_ins", W'(out_ins), W'(NOP));
    repeat (2) step(0, 1, 0, 0, 32'h0);
    // Reset while full.
    step(1, 0, 0, 0, 32'h3000);
    step(1, 0, 0, 0, 32'h3004);
    step(0, 0, 0, 1, 32'h0);
    chk("rst2_word", {out_ins, out_pc, out_aux}, {NOP, RPC, {AUX_W{1'b0}}});
    repeat (2) step(0, 1, 0, 0, 32'h0);
`ifdef PIPE_STAGE_STAT_EN
    // Three empty cycles then four stalled cycles after reset.
    step(0, 0, 0, 1, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h3000);
    repeat (4) step(0, 0, 0, 0, 32'h0);
    chk("stat_stall", W'(stall_cnt), W'(32'd4));
    chk("stat_bubble", W'(bubble_cnt), W'(32'd3));
`endif
    // Random traffic with alternating downstream pressure.
    for (int i = 0; i < 3000; i++) begin
      logic v, r, f, rs;
      v  = ($urandom_range(0, 3) != 0);
      r  = ((i / 200) % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      f  = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 299) == 0);
      step(v, r, f, rs, $urandom);
    end
    step(0, 1, 0, 0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
